// File: rtl/branch_resolve_if.sv
// Branch resolve bus: groups the IF-side prediction push, the MEM-side
// resolution, and the flush / predictor-training / statistics outputs.
//   master : pipeline side (drives push_* and resolve_*, observes results)
//   slave  : branch_resolve_unit side
interface branch_resolve_if #(
    parameter int PCW  = 64,
    parameter int CNTW = 32
);
    logic            push_valid;
    logic [PCW-1:0]  push_pc;
    logic            push_pred_taken;
    logic [PCW-1:0]  push_pred_target;
    logic            push_ready;
    logic            resolve_valid;
    logic [PCW-1:0]  resolve_pc;
    logic            resolve_taken;
    logic [PCW-1:0]  resolve_target;
    logic            flush;
    logic [PCW-1:0]  redirect_pc;
    logic            upd_valid;
    logic [PCW-1:0]  upd_pc;
    logic            upd_taken;
    logic [CNTW-1:0] branch_count;
    logic [CNTW-1:0] mispredict_count;
    logic            err;

    modport master (
        output push_valid, push_pc, push_pred_taken, push_pred_target,
        output resolve_valid, resolve_pc, resolve_taken, resolve_target,
        input  push_ready, flush, redirect_pc, upd_valid, upd_pc, upd_taken,
        input  branch_count, mispredict_count, err
    );

    modport slave (
        input  push_valid, push_pc, push_pred_taken, push_pred_target,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
        output push_ready, flush, redirect_pc, upd_valid, upd_pc, upd_taken,
        output branch_count, mispredict_count, err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: keeps an in-order queue of in-flight branch
// predictions, checks each MEM resolution against the oldest record,
// raises a one-cycle flush with the corrected fetch PC on a mispredict,
// drives the predictor training strobe and keeps saturating statistics.
// Ports:
//   clk    : clock
//   resetl : asynchronous active-low reset
//   bus    : branch_resolve_if slave (push, resolve, flush/redirect,
//            training update, counters, sticky err)
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PCW   = 64,
    parameter int CNTW  = 32
) (
    input  logic                clk,
    input  logic                resetl,
    branch_resolve_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Increment that sticks at all ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (v == {CNTW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNTW-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [PCW-1:0]  pc_mem_r     [DEPTH];
    logic            taken_mem_r  [DEPTH];
    logic [PCW-1:0]  target_mem_r [DEPTH];

    logic [AW:0]     wr_ptr_r, rd_ptr_r;
    logic [AW:0]     wr_ptr_nxt_s, rd_ptr_nxt_s;

    logic            flush_r, flush_nxt_s;
    logic [PCW-1:0]  redirect_pc_r, redirect_pc_nxt_s;
    logic            upd_valid_r, upd_valid_nxt_s;
    logic [PCW-1:0]  upd_pc_r, upd_pc_nxt_s;
    logic            upd_taken_r, upd_taken_nxt_s;
    logic [CNTW-1:0] branch_count_r, branch_count_nxt_s;
    logic [CNTW-1:0] mispredict_count_r, mispredict_count_nxt_s;
    logic            err_r, err_nxt_s;

    logic            full_s, empty_s;
    logic [PCW-1:0]  head_pc_s, head_target_s;
    logic            head_taken_s;
    logic            push_acc_s, res_ok_s, res_bad_s, pop_s, mispred_s, mem_we_s;

    // Queue status and head-entry decode; the extra pointer MSB tells full from empty.
    always_comb begin
        empty_s       = (wr_ptr_r == rd_ptr_r);
        full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        head_pc_s     = pc_mem_r[rd_ptr_r[AW-1:0]];
        head_taken_s  = taken_mem_r[rd_ptr_r[AW-1:0]];
        head_target_s = target_mem_r[rd_ptr_r[AW-1:0]];
    end

    // Resolution classification and pointer / output next-state.
    always_comb begin
        push_acc_s   = bus.push_valid && !full_s;
        res_ok_s     = bus.resolve_valid && !empty_s && (bus.resolve_pc == head_pc_s);
        res_bad_s    = bus.resolve_valid && (empty_s || (bus.resolve_pc != head_pc_s));
        // A PC mismatch still discards the head; an empty queue has nothing to pop.
        pop_s        = bus.resolve_valid && !empty_s;
        mispred_s    = res_ok_s &&
                       ((head_taken_s != bus.resolve_taken) ||
                        (head_taken_s && bus.resolve_taken &&
                         (head_target_s != bus.resolve_target)));
        // Records pushed during a mispredicting resolve are wrong-path.
        mem_we_s     = push_acc_s && !mispred_s;

        rd_ptr_nxt_s = rd_ptr_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        wr_ptr_nxt_s = wr_ptr_r;
        if (mispred_s) begin
            wr_ptr_nxt_s = rd_ptr_nxt_s;
        end else if (push_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        flush_nxt_s            = mispred_s;
        upd_valid_nxt_s        = res_ok_s;
        redirect_pc_nxt_s      = redirect_pc_r;
        upd_pc_nxt_s           = upd_pc_r;
        upd_taken_nxt_s        = upd_taken_r;
        branch_count_nxt_s     = branch_count_r;
        mispredict_count_nxt_s = mispredict_count_r;
        err_nxt_s              = err_r || res_bad_s;

        if (res_ok_s) begin
            upd_pc_nxt_s       = bus.resolve_pc;
            upd_taken_nxt_s    = bus.resolve_taken;
            branch_count_nxt_s = sat_inc(branch_count_r);
        end else begin
            upd_pc_nxt_s       = upd_pc_r;
            upd_taken_nxt_s    = upd_taken_r;
            branch_count_nxt_s = branch_count_r;
        end

        if (mispred_s) begin
            mispredict_count_nxt_s = sat_inc(mispredict_count_r);
            // Not-taken fall-through wraps modulo 2^PCW.
            redirect_pc_nxt_s      = bus.resolve_taken ? bus.resolve_target
                                                       : bus.resolve_pc + PCW'(4);
        end else begin
            mispredict_count_nxt_s = mispredict_count_r;
            redirect_pc_nxt_s      = redirect_pc_r;
        end
    end

    // Record storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]     <= {PCW{1'b0}};
                taken_mem_r[i]  <= 1'b0;
                target_mem_r[i] <= {PCW{1'b0}};
            end
        end else if (mem_we_s) begin
            pc_mem_r[wr_ptr_r[AW-1:0]]     <= bus.push_pc;
            taken_mem_r[wr_ptr_r[AW-1:0]]  <= bus.push_pred_taken;
            target_mem_r[wr_ptr_r[AW-1:0]] <= bus.push_pred_target;
        end
    end

    // Pointer, pulse, counter and error registers.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            wr_ptr_r           <= {(AW+1){1'b0}};
            rd_ptr_r           <= {(AW+1){1'b0}};
            flush_r            <= 1'b0;
            redirect_pc_r      <= {PCW{1'b0}};
            upd_valid_r        <= 1'b0;
            upd_pc_r           <= {PCW{1'b0}};
            upd_taken_r        <= 1'b0;
            branch_count_r     <= {CNTW{1'b0}};
            mispredict_count_r <= {CNTW{1'b0}};
            err_r              <= 1'b0;
        end else begin
            wr_ptr_r           <= wr_ptr_nxt_s;
            rd_ptr_r           <= rd_ptr_nxt_s;
            flush_r            <= flush_nxt_s;
            redirect_pc_r      <= redirect_pc_nxt_s;
            upd_valid_r        <= upd_valid_nxt_s;
            upd_pc_r           <= upd_pc_nxt_s;
            upd_taken_r        <= upd_taken_nxt_s;
            branch_count_r     <= branch_count_nxt_s;
            mispredict_count_r <= mispredict_count_nxt_s;
            err_r              <= err_nxt_s;
        end
    end

    assign bus.push_ready       = !full_s;
    assign bus.flush            = flush_r;
    assign bus.redirect_pc      = redirect_pc_r;
    assign bus.upd_valid        = upd_valid_r;
    assign bus.upd_pc           = upd_pc_r;
    assign bus.upd_taken        = upd_taken_r;
    assign bus.branch_count     = branch_count_r;
    assign bus.mispredict_count = mispredict_count_r;
    assign bus.err              = err_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios with literal
// expectations plus randomized traffic, all checked against a queue-based
// behavioural model of the in-flight branch records.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int PCW   = 64;
    localparam int CNTW  = 8;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic resetl = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.PCW(PCW), .CNTW(CNTW)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PCW(PCW), .CNTW(CNTW)) dut (
        .clk    (clk),
        .resetl (resetl),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] pc;
        bit          pt;
        logic [63:0] tgt;
    } rec_t;

    rec_t        q[$];
    bit          m_flush, m_upd_valid, m_upd_taken, m_err;
    logic [63:0] m_redirect, m_upd_pc;
    int          m_bc, m_mc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 0; m_upd_valid = 0; m_upd_taken = 0; m_err = 0;
        m_redirect = 64'd0; m_upd_pc = 64'd0; m_bc = 0; m_mc = 0;
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_step();
        bit   full;
        bit   mis;
        rec_t h;
        full = (q.size() == DEPTH);
        mis  = 0;
        m_flush = 0;
        m_upd_valid = 0;
        if (bus.resolve_valid) begin
            if (q.size() == 0) begin
                m_err = 1;
            end else if (q[0].pc != bus.resolve_pc) begin
                m_err = 1;
                h = q.pop_front();
            end else begin
                h = q.pop_front();
                m_upd_valid = 1;
                m_upd_pc    = bus.resolve_pc;
                m_upd_taken = bus.resolve_taken;
                if (m_bc < CMAX) m_bc++;
                if (h.pt != bus.resolve_taken ||
                    (h.pt && bus.resolve_taken && h.tgt != bus.resolve_target)) begin
                    mis = 1;
                    if (m_mc < CMAX) m_mc++;
                    m_flush    = 1;
                    m_redirect = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 64'd4;
                    q.delete();
                end
            end
        end
        if (bus.push_valid && !full && !mis)
            q.push_back('{bus.push_pc, bus.push_pred_taken, bus.push_pred_target});
    endtask

    task automatic check_outputs();
        chk("flush", bus.flush, m_flush);
        chk("upd_valid", bus.upd_valid, m_upd_valid);
        chk("err", bus.err, m_err);
        chk("branch_count", bus.branch_count, m_bc);
        chk("mispredict_count", bus.mispredict_count, m_mc);
        if (m_upd_valid) begin
            chk("upd_pc", bus.upd_pc, m_upd_pc);
            chk("upd_taken", bus.upd_taken, m_upd_taken);
        end
        if (m_flush) chk("redirect_pc", bus.redirect_pc, m_redirect);
    endtask

    task automatic idle();
        bus.push_valid = 1'b0; bus.push_pc = 64'd0;
        bus.push_pred_taken = 1'b0; bus.push_pred_target = 64'd0;
        bus.resolve_valid = 1'b0; bus.resolve_pc = 64'd0;
        bus.resolve_taken = 1'b0; bus.resolve_target = 64'd0;
    endtask

    task automatic push(input logic [63:0] pc, input bit pt, input logic [63:0] tgt);
        bus.push_valid = 1'b1; bus.push_pc = pc;
        bus.push_pred_taken = pt; bus.push_pred_target = tgt;
    endtask

    task automatic res(input logic [63:0] pc, input bit t, input logic [63:0] tgt);
        bus.resolve_valid = 1'b1; bus.resolve_pc = pc;
        bus.resolve_taken = t; bus.resolve_target = tgt;
    endtask

    // Inputs are set before calling; one clock edge, then compare.
    task automatic step();
        chk("push_ready", bus.push_ready, (q.size() != DEPTH));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        idle();
    endtask

    task automatic check_all_zero();
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_upd_valid", bus.upd_valid, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("rst_upd_pc", bus.upd_pc, 64'd0);
        chk("rst_upd_taken", bus.upd_taken, 1'b0);
        chk("rst_branch_count", bus.branch_count, 64'd0);
        chk("rst_mispredict_count", bus.mispredict_count, 64'd0);
        chk("rst_push_ready", bus.push_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        resetl = 1'b0;
        #1;
        model_reset();
        check_all_zero();
        @(negedge clk);
        @(negedge clk);
        resetl = 1'b1;
    endtask

    initial begin
        logic [63:0] rpc, rtgt;
        bit          rt;
        idle();
        resetl = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero();
        resetl = 1'b1;

        // 1: correctly predicted not-taken branch
        push(64'h100, 1'b0, 64'd0); step();
        res(64'h100, 1'b0, 64'd0);  step();
        chk("t1_upd_valid", bus.upd_valid, 1'b1);
        chk("t1_upd_pc", bus.upd_pc, 64'h100);
        chk("t1_upd_taken", bus.upd_taken, 1'b0);
        chk("t1_flush", bus.flush, 1'b0);
        chk("t1_branch_count", bus.branch_count, 64'd1);
        chk("t1_mispredict_count", bus.mispredict_count, 64'd0);

        // 2: direction mispredict flushes the younger records
        push(64'h200, 1'b0, 64'd0); step();
        push(64'h210, 1'b0, 64'd0); step();
        push(64'h220, 1'b0, 64'd0); step();
        res(64'h200, 1'b1, 64'h400); step();
        chk("t2_flush", bus.flush, 1'b1);
        chk("t2_redirect_pc", bus.redirect_pc, 64'h400);
        chk("t2_mispredict_count", bus.mispredict_count, 64'd1);
        res(64'h210, 1'b0, 64'd0); step();
        chk("t2_err", bus.err, 1'b1);
        chk("t2_flush_pulse", bus.flush, 1'b0);

        // 3: target mispredict, push in mispredict cycle dropped, push in flush cycle kept
        do_reset();
        push(64'h300, 1'b1, 64'h500); step();
        res(64'h300, 1'b1, 64'h600); push(64'h999, 1'b0, 64'd0); step();
        chk("t3_flush", bus.flush, 1'b1);
        chk("t3_redirect_pc", bus.redirect_pc, 64'h600);
        push(64'h300, 1'b1, 64'h500); step();
        res(64'h300, 1'b0, 64'd0); step();
        chk("t3_redirect_nt", bus.redirect_pc, 64'h304);
        chk("t3_err_clear", bus.err, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h40); step();
        res(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0); step();
        chk("t3_redirect_wrap", bus.redirect_pc, 64'd0);

        // 4: fill, drop while full, pop in order
        for (int i = 1; i <= 4; i++) begin
            push(64'h10 * i, 1'b0, 64'd0); step();
        end
        chk("t4_full", bus.push_ready, 1'b0);
        push(64'h50, 1'b0, 64'd0); step();
        res(64'h10, 1'b0, 64'd0); push(64'h60, 1'b0, 64'd0); step();
        chk("t4_ready_after_pop", bus.push_ready, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            res(64'h10 * i, 1'b0, 64'd0); step();
            chk("t4_upd_pc", bus.upd_pc, 64'h10 * i);
        end
        chk("t4_err_clear", bus.err, 1'b0);

        // 5: empty-queue resolve and PC mismatch
        do_reset();
        res(64'h100, 1'b0, 64'd0); step();
        chk("t5_err_empty", bus.err, 1'b1);
        chk("t5_no_upd", bus.upd_valid, 1'b0);
        chk("t5_bc", bus.branch_count, 64'd0);
        push(64'h100, 1'b0, 64'd0); step();
        res(64'h104, 1'b0, 64'd0);  step();
        chk("t5_mismatch_no_upd", bus.upd_valid, 1'b0);
        push(64'h500, 1'b0, 64'd0); step();
        res(64'h500, 1'b0, 64'd0);  step();
        chk("t5_head_popped", bus.upd_pc, 64'h500);

        // 6: reset mid-queue, then counter saturation
        push(64'h700, 1'b0, 64'd0); step();
        push(64'h710, 1'b1, 64'h20); step();
        res(64'h700, 1'b1, 64'h800); step();
        do_reset();
        step();
        chk("t6_no_flush", bus.flush, 1'b0);
        for (int i = 0; i < 260; i++) begin
            push(64'h1000 + 64'(i * 4), 1'b0, 64'd0); step();
            res(64'h1000 + 64'(i * 4), 1'b0, 64'd0); step();
        end
        chk("t6_bc_saturated", bus.branch_count, 64'hFF);
        chk("t6_mc_zero", bus.mispredict_count, 64'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(1, 0) == 1)
                push({$urandom, $urandom} & ~64'd3, $urandom_range(1, 0) == 1,
                     {$urandom, $urandom} & ~64'd3);
            if ($urandom_range(99, 0) < 45) begin
                rt   = ($urandom_range(1, 0) == 1);
                rpc  = {$urandom, $urandom};
                rtgt = {$urandom, $urandom};
                if (q.size() > 0 && $urandom_range(9, 0) != 0) begin
                    rpc = q[0].pc;
                    if ($urandom_range(3, 0) != 0) begin
                        rt = q[0].pt;
                        rtgt = q[0].tgt;
                    end
                end
                res(rpc, rt, rtgt);
            end
            step();
            if (c == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
